// File: rtl/seg_scan_driver.sv
// Four-digit seven-segment scan controller; outputs come from registered state (blank_lz reaches en combinationally).
// New values are applied only at frame boundaries. There is no backpressure: load is always accepted.
module seg_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int GAP_CYC     = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic        load,
    input  logic        blank_lz,
    output logic [0:3]  x,
    output logic [0:1]  dig,
    output logic        en,
    output logic        pending,
    output logic        frame_tick
);
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_GAP  = CW'(GAP_CYC);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    dig_q, dig_d;
    logic [15:0]   active_q, active_d;
    logic [15:0]   pend_reg_q, pend_reg_d;
    logic          pend_valid_q, pend_valid_d;
    logic          frame_tick_q, frame_tick_d;

    logic          slot_wrap;
    logic          boundary;
    logic [3:0]    nibble;
    logic          lz0, lz1, lz2;
    logic          digit_blanked;
    logic          show_phase;

    assign slot_wrap = (cnt_q == CNT_LAST);
    assign boundary  = slot_wrap && (dig_q == 2'd3);

    always_comb begin
        cnt_d        = slot_wrap ? '0 : cnt_q + 1'b1;
        dig_d        = slot_wrap ? dig_q + 2'd1 : dig_q;
        active_d     = active_q;
        pend_reg_d   = pend_reg_q;
        pend_valid_d = pend_valid_q;
        frame_tick_d = boundary;
        // A load on the boundary edge itself bypasses the pending register.
        if (boundary) begin
            if (load) begin
                active_d     = value;
                pend_valid_d = 1'b0;
            end else if (pend_valid_q) begin
                active_d     = pend_reg_q;
                pend_valid_d = 1'b0;
            end
        end else if (load) begin
            pend_reg_d   = value;
            pend_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            dig_q        <= 2'd0;
            active_q     <= 16'h0000;
            pend_reg_q   <= 16'h0000;
            pend_valid_q <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            dig_q        <= dig_d;
            active_q     <= active_d;
            pend_reg_q   <= pend_reg_d;
            pend_valid_q <= pend_valid_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    always_comb begin
        nibble = active_q[3:0];
        case (dig_q)
            2'd0:    nibble = active_q[15:12];
            2'd1:    nibble = active_q[11:8];
            2'd2:    nibble = active_q[7:4];
            default: nibble = active_q[3:0];
        endcase
    end

    // Leading-zero runs: digit d is blankable only if all digits left of it are zero too.
    assign lz0 = (active_q[15:12] == 4'h0);
    assign lz1 = lz0 && (active_q[11:8] == 4'h0);
    assign lz2 = lz1 && (active_q[7:4] == 4'h0);

    always_comb begin
        digit_blanked = 1'b0;
        case (dig_q)
            2'd0:    digit_blanked = blank_lz && lz0;
            2'd1:    digit_blanked = blank_lz && lz1;
            2'd2:    digit_blanked = blank_lz && lz2;
            default: digit_blanked = 1'b0;
        endcase
    end

    assign show_phase = (cnt_q >= CNT_GAP);

    assign x          = nibble;
    assign dig        = dig_q;
    assign en         = show_phase && !digit_blanked;
    assign pending    = pend_valid_q;
    assign frame_tick = frame_tick_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: directed scenarios plus random loads/blanking/resets against a cycle-count model.
module tb_seg_scan_driver;
    localparam int RD    = 8;
    localparam int GAP   = 2;
    localparam int FRAME = 4 * RD;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value;
    logic        load;
    logic        blank_lz;
    logic [0:3]  x;
    logic [0:1]  dig;
    logic        en;
    logic        pending;
    logic        frame_tick;

    int checks   = 0;
    int failures = 0;

    // Reference state: edges since reset, displayed value, held value.
    int          t      = 0;
    bit          armed  = 0;
    logic [15:0] m_act  = 16'h0;
    logic [15:0] m_pend = 16'h0;
    bit          m_pv   = 0;
    bit          m_ft   = 0;

    seg_scan_driver #(.REFRESH_DIV(RD), .GAP_CYC(GAP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .load       (load),
        .blank_lz   (blank_lz),
        .x          (x),
        .dig        (dig),
        .en         (en),
        .pending    (pending),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
        end
    endtask

    function automatic int m_dig();
        return (t / RD) % 4;
    endfunction

    function automatic logic [3:0] m_nib();
        logic [15:0] s;
        s = m_act >> (4 * (3 - m_dig()));
        return s[3:0];
    endfunction

    function automatic bit m_en(input bit bl);
        logic [15:0] lead;
        int d;
        d = m_dig();
        if ((t % RD) < GAP) return 0;
        lead = m_act >> (4 * (3 - d));
        if (bl && d < 3 && lead == 16'h0) return 0;
        return 1;
    endfunction

    task automatic check_all();
        if (!armed) return;
        check("x",          32'(x),          32'(m_nib()));
        check("dig",        32'(dig),        32'(m_dig()));
        check("en",         32'(en),         32'(m_en(blank_lz)));
        check("pending",    32'(pending),    32'(m_pv));
        check("frame_tick", 32'(frame_tick), 32'(m_ft));
    endtask

    task automatic model_edge(input bit r, input bit ld, input logic [15:0] v);
        bit bnd;
        if (!r) begin
            t = 0; m_act = 16'h0; m_pend = 16'h0; m_pv = 0; m_ft = 0;
            armed = 1;
            return;
        end
        bnd  = (t % FRAME) == FRAME - 1;
        m_ft = bnd;
        if (bnd) begin
            if (ld) begin
                m_act = v; m_pv = 0;
            end else if (m_pv) begin
                m_act = m_pend; m_pv = 0;
            end
        end else if (ld) begin
            m_pend = v; m_pv = 1;
        end
        t++;
    endtask

    // One clock: check outputs, apply inputs, confirm blank_lz reaches en at once, take the edge.
    task automatic cycle(input bit r, input bit ld, input logic [15:0] v, input bit bl);
        check_all();
        rst_n = r; load = ld; value = v; blank_lz = bl;
        #1;
        if (armed) check("en_comb", 32'(en), 32'(m_en(bl)));
        @(posedge clk);
        model_edge(r, ld, v);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 16'h0, blank_lz);
    endtask

    task automatic idle_until(input int phase);
        for (int i = 0; i < FRAME && (t % FRAME) != phase; i++) cycle(1, 0, 16'h0, blank_lz);
    endtask

    initial begin
        rst_n = 0; load = 0; value = 16'h0; blank_lz = 0;
        @(negedge clk);
        cycle(0, 0, 16'h0, 0);
        cycle(0, 0, 16'h0, 0);
        idle(2 * FRAME);

        // Mid-frame load waits for the boundary.
        idle_until(10);
        cycle(1, 1, 16'h1A2F, 0);
        idle(FRAME + 4);

        // Last load before the boundary wins.
        idle_until(3);
        cycle(1, 1, 16'h1111, 0);
        idle_until(15);
        cycle(1, 1, 16'h2222, 0);
        idle_until(0);
        idle(FRAME);

        // Overwrite then a load exactly on the boundary edge.
        idle_until(3);
        cycle(1, 1, 16'h1111, 0);
        idle_until(15);
        cycle(1, 1, 16'h2222, 0);
        idle_until(FRAME - 1);
        cycle(1, 1, 16'h3333, 0);
        idle(FRAME);

        // Leading-zero blanking.
        idle_until(FRAME - 1);
        cycle(1, 1, 16'h0050, 1);
        idle(FRAME);
        idle_until(FRAME - 1);
        cycle(1, 1, 16'h0000, 1);
        idle(FRAME);
        blank_lz = 0;
        idle(FRAME);

        // Reset during the dig 2 slot with a load pending.
        idle_until(FRAME - 1);
        cycle(1, 1, 16'hBEEF, 0);
        idle_until(17);
        cycle(1, 1, 16'h4321, 0);
        idle(2);
        cycle(0, 0, 16'h0, 0);
        idle(FRAME + 8);

        // Random loads, blank toggles and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            logic [15:0] v;
            bit ld, bl, r;
            v  = 16'($urandom);
            v  = v >> (4 * $urandom_range(0, 3));
            ld = ($urandom_range(0, 7) == 0);
            bl = ($urandom_range(0, 15) == 0) ? ~blank_lz : blank_lz;
            r  = ($urandom_range(0, 299) != 0);
            cycle(r, ld, v, bl);
        end
        check_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed scan controller for the four-digit seven-segment display. It latches a 16-bit hex value through a load strobe and cycles through the four digit positions. For each position it drives the nibble, digit index and enable into the downstream hex-to-segment/anode decoder. Inter-digit blanking gaps suppress ghosting, optional leading-zero blanking hides unused digits, and new values are applied only at frame boundaries so a digit never changes mid-frame.

## Interface
- REFRESH_DIV, 100000: clock cycles per digit slot (1 kHz per digit at 100 MHz); must be ≥ 4.
- GAP_CYC, 1000: blanked cycles at the start of each slot; 1 ≤ GAP_CYC < REFRESH_DIV.
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- value  input  16  hex value to display; value[15:12] is the leftmost digit.
- load  input  1  single-cycle strobe; captures value.
- blank_lz  input  1  level; 1 = blank leading zero digits.
- x  output  [0:3]  nibble for the current digit (x[0] = MSB).
- dig  output  [0:1]  digit index; 0 = leftmost (value[15:12]), 3 = rightmost (value[3:0]).
- en  output  1  decoder enable; 0 blanks all anodes.
- pending  output  1  a loaded value is waiting for the next frame boundary.
- frame_tick  output  1  one-cycle pulse when a frame boundary occurs (slot of dig 3 ends).

## Operation
- Registers:
  - cnt: slot counter, 0..REFRESH_DIV-1, width $clog2(REFRESH_DIV).
  - dig: 2-bit digit index.
  - active: 16-bit value currently displayed.
  - pend_reg: 16-bit held value.
  - pend_valid: pending flag.
- Per-slot state machine, decoded from cnt:
  - GAP: cnt < GAP_CYC.
  - SHOW: cnt ≥ GAP_CYC.
- Counter: each edge, cnt increments. At cnt = REFRESH_DIV-1 it wraps to 0 and dig increments modulo 4 (3 → 0).
- Frame boundary: the edge where cnt wraps and dig goes 3 → 0. frame_tick is high for exactly the cycle after that edge.
- Load:
  - At a non-boundary edge, load = 1 stores value into pend_reg and sets pend_valid.
  - A later load before the boundary overwrites pend_reg; the last one wins.
- At the boundary edge, in priority order:
  - load = 1: active ← value, pend_valid ← 0.
  - else pend_valid = 1: active ← pend_reg, pend_valid ← 0.
  - else active is unchanged.
- pending = pend_valid.
- x = active nibble selected by dig:
  - dig 0 → [15:12]
  - dig 1 → [11:8]
  - dig 2 → [7:4]
  - dig 3 → [3:0]
- Leading-zero blanking:
  - Digit d (0..2) is blanked when blank_lz = 1 and every nibble of active from digit 0 through d is zero.
  - Digit 3 is never blanked, so value 0 shows "0".
- en = 1 only in SHOW and when the current digit is not blanked; otherwise 0.
- x, dig, en, pending and frame_tick are functions of registered state only. There is no combinational path from value or load to any output; blank_lz is the only input that reaches en combinationally.

## Timing
- Reset (rst_n low at an edge) sets:
  - cnt = 0, dig = 0, active = 0x0000, pend_reg = 0, pend_valid = 0.
  - Outputs: x = 0, dig = 0, en = 0, pending = 0, frame_tick = 0.
- Reset mid-frame or mid-pending: any pending load is dropped and scanning restarts at digit 0, cnt 0.
- Slot length is REFRESH_DIV cycles; frame length is 4·REFRESH_DIV cycles. Each slot has GAP_CYC cycles with en = 0, then REFRESH_DIV-GAP_CYC cycles with en possibly 1.
- dig and x change only on slot-wrap edges, while en is already 0 (the gap begins in the same cycle). The decoder therefore never sees a digit change while enabled.
- Load-to-display latency depends on when the load arrives:
  - Load at the boundary edge itself: the value shows in the following slot (dig 0).
  - Otherwise: it shows at the next boundary, at most 4·REFRESH_DIV cycles later.
- First boundary after reset deasserts: 4·REFRESH_DIV edges later.
- blank_lz changes take effect on en in the same cycle.

## Test plan
Bench parameters: REFRESH_DIV = 8, GAP_CYC = 2.
- Reset, then idle for 2 frames:
  - dig sequences 0,1,2,3 every 8 cycles.
  - en = 0 for cnt 0–1 and en = 1 for cnt 2–7 in every slot.
  - x = 0 throughout, and frame_tick pulses every 32 cycles.
- Load 0x1A2F mid-frame:
  - pending = 1 until the boundary, with the old digits unchanged.
  - After the boundary, x = 1, A, 2, F for dig 0..3, and pending = 0.
- Load 0x1111, then 0x2222 before the boundary, then a load of 0x3333 exactly on the boundary edge:
  - 0x2222 replaces 0x1111 as the pending value.
  - 0x3333 becomes active at that boundary, and pending = 0.
- blank_lz = 1 with active 0x0050:
  - en stays 0 in the dig 0 and dig 1 slots.
  - en follows the normal gap/show pattern for dig 2 (x = 5) and dig 3 (x = 0).
- blank_lz = 1 with active 0x0000: only digit 3 enables, showing x = 0.
- Assert rst_n = 0 for one edge during the dig 2 slot with pending = 1:
  - The next cycle shows dig = 0, en = 0, pending = 0, active = 0.
  - Scanning resumes from cnt 0.
